// File: rtl/spi_config_bank.sv
// spi_config_bank: per-channel SPI mode/width configuration with shadow registers.
// Writes land in a per-channel shadow and are committed to the active registers
// when that channel's SPI engine is idle, so a frame never sees its mode change.
//
// Ports:
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   config_req      write request; accepted when config_ack is low
//   config_ch       target channel of the write
//   config_data     {cpol, cpha, spi_width} to write
//   config_ack      one-cycle acknowledge, the cycle after acceptance
//   config_err      one-cycle error flag alongside config_ack
//   ch_busy         per-channel frame-in-progress from the SPI engines
//   cpol, cpha      active clock polarity / phase per channel
//   spi_width       active width per channel, channel i at [i*W +: W]
//   pending         shadow holds an uncommitted value, per channel
//   rd_ch           readback channel select
//   rd_data         registered {pending, cpol, cpha, spi_width} of rd_ch
module spi_config_bank #(
    parameter int unsigned SPI_MAX_WIDTH_LOG = 4,
    parameter int unsigned CH_NUM            = 4,
    parameter int unsigned CH_LOG            = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                config_req,
    input  logic [CH_LOG-1:0]                   config_ch,
    input  logic [SPI_MAX_WIDTH_LOG+1:0]        config_data,
    output logic                                config_ack,
    output logic                                config_err,
    input  logic [CH_NUM-1:0]                   ch_busy,
    output logic [CH_NUM-1:0]                   cpol,
    output logic [CH_NUM-1:0]                   cpha,
    output logic [CH_NUM*SPI_MAX_WIDTH_LOG-1:0] spi_width,
    output logic [CH_NUM-1:0]                   pending,
    input  logic [CH_LOG-1:0]                   rd_ch,
    output logic [SPI_MAX_WIDTH_LOG+2:0]        rd_data
);

    localparam int unsigned W     = SPI_MAX_WIDTH_LOG;
    localparam int unsigned CFG_W = SPI_MAX_WIDTH_LOG + 2;
    localparam int unsigned RD_W  = SPI_MAX_WIDTH_LOG + 3;

    logic [CFG_W-1:0]      shadow_q [CH_NUM];
    logic [CFG_W-1:0]      shadow_d [CH_NUM];
    logic [CH_NUM-1:0]     pending_d;
    logic [CH_NUM-1:0]     cpol_d;
    logic [CH_NUM-1:0]     cpha_d;
    logic [CH_NUM*W-1:0]   spi_width_d;
    logic [RD_W-1:0]       rd_data_d;
    logic                  config_ack_d;
    logic                  config_err_d;

    logic                  accept;
    logic                  ch_ok;
    logic                  width_ok;
    logic                  legal;

    // Request decode: the ack cycle blocks acceptance, giving one accept per two cycles.
    always_comb begin
        accept       = config_req && !config_ack;
        ch_ok        = 32'(config_ch) < CH_NUM;
        width_ok     = config_data[W-1:0] != '0;
        legal        = accept && ch_ok && width_ok;
        config_ack_d = accept;
        config_err_d = accept && !legal;
    end

    // Commit and shadow write per channel. Commit reads the old shadow, so a
    // same-edge write leaves the new value pending for the next idle edge.
    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending;
        cpol_d      = cpol;
        cpha_d      = cpha;
        spi_width_d = spi_width;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (pending[i] && !ch_busy[i]) begin
                cpol_d[i]            = shadow_q[i][CFG_W-1];
                cpha_d[i]            = shadow_q[i][CFG_W-2];
                spi_width_d[i*W +: W] = shadow_q[i][W-1:0];
                pending_d[i]         = 1'b0;
            end
            if (legal && (config_ch == CH_LOG'(i))) begin
                shadow_d[i]  = config_data;
                pending_d[i] = 1'b1;
            end
        end
    end

    // Readback mux over pre-update state; out-of-range channels read as zero.
    always_comb begin
        rd_data_d = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (rd_ch == CH_LOG'(i)) begin
                rd_data_d = {pending[i], cpol[i], cpha[i], spi_width[i*W +: W]};
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                shadow_q[i] <= '0;
            end
            pending    <= '0;
            cpol       <= '0;
            cpha       <= '0;
            spi_width  <= '0;
            rd_data    <= '0;
            config_ack <= 1'b0;
            config_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            pending    <= pending_d;
            cpol       <= cpol_d;
            cpha       <= cpha_d;
            spi_width  <= spi_width_d;
            rd_data    <= rd_data_d;
            config_ack <= config_ack_d;
            config_err <= config_err_d;
        end
    end

endmodule

// File: tb/tb_spi_config_bank.sv
// Testbench for spi_config_bank: directed writes, scoreboarded ack/err responses,
// direct checks of active/pending/readback state, and a CH_NUM=3 instance.
module tb_spi_config_bank;

    logic        clk;
    logic        rst_n;

    // Default instance (CH_NUM=4)
    logic        config_req;
    logic [1:0]  config_ch;
    logic [5:0]  config_data;
    logic        config_ack;
    logic        config_err;
    logic [3:0]  ch_busy;
    logic [3:0]  cpol;
    logic [3:0]  cpha;
    logic [15:0] spi_width;
    logic [3:0]  pending;
    logic [1:0]  rd_ch;
    logic [6:0]  rd_data;

    // CH_NUM=3 instance
    logic        req3;
    logic [1:0]  ch3;
    logic [5:0]  data3;
    logic        ack3;
    logic        err3;
    logic [2:0]  busy3;
    logic [2:0]  cpol3;
    logic [2:0]  cpha3;
    logic [11:0] width3;
    logic [2:0]  pending3;
    logic [1:0]  rd_ch3;
    logic [6:0]  rd_data3;

    int checks = 0;
    int errors = 0;
    int ack_count = 0;
    int ack_base;

    bit exp_q[$];
    bit exp_q3[$];

    spi_config_bank dut (
        .clk(clk), .rst_n(rst_n),
        .config_req(config_req), .config_ch(config_ch), .config_data(config_data),
        .config_ack(config_ack), .config_err(config_err),
        .ch_busy(ch_busy), .cpol(cpol), .cpha(cpha), .spi_width(spi_width),
        .pending(pending), .rd_ch(rd_ch), .rd_data(rd_data)
    );

    spi_config_bank #(.SPI_MAX_WIDTH_LOG(4), .CH_NUM(3), .CH_LOG(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .config_req(req3), .config_ch(ch3), .config_data(data3),
        .config_ack(ack3), .config_err(err3),
        .ch_busy(busy3), .cpol(cpol3), .cpha(cpha3), .spi_width(width3),
        .pending(pending3), .rd_ch(rd_ch3), .rd_data(rd_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop the expected err flag whenever an ack appears.
    always @(negedge clk) begin
        if (rst_n && config_ack) begin
            ack_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack4_unexpected: got ack err=%0b expected no ack", config_err);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (config_err !== e) begin
                    errors++;
                    $display("FAIL ack4_err: got %0b expected %0b", config_err, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ack3) begin
            checks++;
            if (exp_q3.size() == 0) begin
                errors++;
                $display("FAIL ack3_unexpected: got ack err=%0b expected no ack", err3);
            end else begin
                bit e;
                e = exp_q3.pop_front();
                if (err3 !== e) begin
                    errors++;
                    $display("FAIL ack3_err: got %0b expected %0b", err3, e);
                end
            end
        end
    end

    // Issue one request at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] ch, input logic [5:0] data, input bit exp_err);
        config_req  = 1'b1;
        config_ch   = ch;
        config_data = data;
        exp_q.push_back(exp_err);
        @(negedge clk);
        config_req = 1'b0;
    endtask

    task automatic issue3(input logic [1:0] ch, input logic [5:0] data, input bit exp_err);
        req3  = 1'b1;
        ch3   = ch;
        data3 = data;
        exp_q3.push_back(exp_err);
        @(negedge clk);
        req3 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        config_req = 1'b0; config_ch = '0; config_data = '0; ch_busy = '0; rd_ch = '0;
        req3 = 1'b0; ch3 = '0; data3 = '0; busy3 = '0; rd_ch3 = '0;

        #12;
        chk("rst_cpol", 32'(cpol), 32'h0);
        chk("rst_width", 32'(spi_width), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_ack", 32'(config_ack), 32'h0);

        // Basic write on the first edge after reset release: ch2 {1,0,8}
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'd2, 6'b10_1000, 1'b0);
        chk("basic_pending_n", 32'(pending), 32'h4);
        chk("basic_cpol_n", 32'(cpol), 32'h0);
        @(negedge clk);
        chk("basic_pending_n1", 32'(pending), 32'h0);
        chk("basic_cpol", 32'(cpol), 32'h4);
        chk("basic_cpha", 32'(cpha), 32'h0);
        chk("basic_width", 32'(spi_width), 32'h0800);
        rd_ch = 2'd2;
        @(negedge clk);
        chk("rd_ch2", 32'(rd_data), 32'h28);

        // Deferred commit while ch1 busy: {0,1,5}
        ch_busy = 4'b0010;
        issue(2'd1, 6'b01_0101, 1'b0);
        rd_ch = 2'd1;
        repeat (10) begin
            chk("defer_pending1", 32'(pending[1]), 32'h1);
            chk("defer_ch1", 32'({cpol[1], cpha[1], spi_width[7:4]}), 32'h0);
            @(negedge clk);
        end
        chk("defer_rd_ch1", 32'(rd_data), 32'h40);
        ch_busy = 4'b0000;
        @(negedge clk);
        chk("defer_commit_ch1", 32'({cpol[1], cpha[1], spi_width[7:4]}), 32'h15);
        chk("defer_pending_clr", 32'(pending), 32'h0);

        // Last write wins on busy ch0: width 3 then 7
        ch_busy = 4'b0001;
        issue(2'd0, 6'h03, 1'b0);
        @(negedge clk);
        issue(2'd0, 6'h07, 1'b0);
        @(negedge clk);
        chk("lww_hold_width", 32'(spi_width[3:0]), 32'h0);
        chk("lww_pending", 32'(pending), 32'h1);
        ch_busy = 4'b0000;
        @(negedge clk);
        chk("lww_width", 32'(spi_width[3:0]), 32'h7);
        chk("lww_pending_clr", 32'(pending), 32'h0);

        // Zero width on ch3 is rejected without state change
        issue(2'd3, 6'b11_0000, 1'b1);
        @(negedge clk);
        chk("err_w0_pending", 32'(pending), 32'h0);
        chk("err_w0_cpol", 32'(cpol), 32'h4);
        chk("err_w0_cpha", 32'(cpha), 32'h2);
        chk("err_w0_width", 32'(spi_width), 32'h0857);

        // CH_NUM=3 instance: legal ch2 write, then out-of-range ch3
        issue3(2'd2, 6'b11_1001, 1'b0);
        @(negedge clk);
        issue3(2'd3, 6'b11_1001, 1'b1);
        rd_ch3 = 2'd2;
        @(negedge clk);
        chk("ch3_cpol", 32'(cpol3), 32'h4);
        chk("ch3_cpha", 32'(cpha3), 32'h4);
        chk("ch3_width", 32'(width3), 32'h900);
        chk("ch3_pending", 32'(pending3), 32'h0);
        chk("ch3_rd2", 32'(rd_data3), 32'h39);
        rd_ch3 = 2'd3;
        @(negedge clk);
        chk("ch3_rd_oob", 32'(rd_data3), 32'h0);

        // Sustained request for six edges yields three acceptances
        ack_base = ack_count;
        config_ch = 2'd3;
        config_data = 6'h01;
        config_req = 1'b1;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        repeat (6) @(negedge clk);
        config_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_acks", 32'(ack_count - ack_base), 32'd3);
        chk("held_width", 32'(spi_width), 32'h1857);

        // Asynchronous reset with pending ch1 and nonzero active state
        ch_busy = 4'b0010;
        issue(2'd1, 6'b11_0010, 1'b0);
        @(negedge clk);
        chk("pre_rst_pending", 32'(pending), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cpol", 32'(cpol), 32'h0);
        chk("arst_cpha", 32'(cpha), 32'h0);
        chk("arst_width", 32'(spi_width), 32'h0);
        chk("arst_pending", 32'(pending), 32'h0);
        chk("arst_rd", 32'(rd_data), 32'h0);
        chk("arst_ack_err", 32'({config_ack, config_err}), 32'h0);

        // First request after release is accepted; discarded ch1 shadow never commits
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'd0, 6'b10_0100, 1'b0);
        ch_busy = 4'b0000;
        @(negedge clk);
        chk("post_rst_cpol", 32'(cpol), 32'h1);
        chk("post_rst_cpha", 32'(cpha), 32'h0);
        chk("post_rst_width", 32'(spi_width), 32'h0004);
        chk("post_rst_pending", 32'(pending), 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drain4", 32'(exp_q.size()), 32'h0);
        chk("sb_drain3", 32'(exp_q3.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
